vx_lsu_mem_responder: RTL and testbench

Memory-side responder for the LSU memory interface: accepts multi-lane load, store and atomic requests from an LSU slice, services them lane by lane against a local word-addressed register array, and returns tagged per-lane responses. It sits on the slave end of one `lsu_mem_if` channel, for example as a core-local scratchpad or atomic test target. Lanes within one request are serialized in ascending lane order, so same-address atomics from different lanes resolve deterministically.

---
 rtl/vx_lsu_mem_responder_if.sv | 29 ++
 rtl/vx_lsu_mem_responder.sv | 109 ++++++++++
 tb/tb_vx_lsu_mem_responder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/vx_lsu_mem_responder_if.sv
// vx_lsu_mem_responder_if: LSU memory channel; master drives req_*/rsp_ready, slave drives req_ready/rsp_*
interface vx_lsu_mem_responder_if #(
  parameter int NUM_LANES  = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int TAG_WIDTH  = 8
);
  logic                            req_valid;
  logic                            req_rw;
  logic [2:0]                      req_amo;
  logic [NUM_LANES-1:0]            req_mask;
  logic [4*NUM_LANES-1:0]          req_byteen;
  logic [ADDR_WIDTH*NUM_LANES-1:0] req_addr;
  logic [32*NUM_LANES-1:0]         req_data;
  logic [TAG_WIDTH-1:0]            req_tag;
  logic                            req_ready;
  logic                            rsp_valid;
  logic [NUM_LANES-1:0]            rsp_mask;
  logic [32*NUM_LANES-1:0]         rsp_data;
  logic [TAG_WIDTH-1:0]            rsp_tag;
  logic                            rsp_ready;
  modport master (
    output req_valid, req_rw, req_amo, req_mask, req_byteen, req_addr, req_data, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_mask, rsp_data, rsp_tag
  );
  modport slave (
    input  req_valid, req_rw, req_amo, req_mask, req_byteen, req_addr, req_data, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_mask, rsp_data, rsp_tag
  );
endinterface

// File: rtl/vx_lsu_mem_responder.sv
// vx_lsu_mem_responder: lane-serial load/store/atomic responder on a word array; ports clk, reset, bus (slave side of the LSU channel)
module vx_lsu_mem_responder #(
  parameter int NUM_LANES  = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int TAG_WIDTH  = 8
) (
  input logic clk,
  input logic reset,
  vx_lsu_mem_responder_if.slave bus
);
  localparam int LW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
  typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;
  state_t state_q, state_d;
  logic rw_q, rw_d;
  logic [2:0] amo_q, amo_d;
  logic [NUM_LANES-1:0] mask_q, mask_d, pend_q, pend_d;
  logic [4*NUM_LANES-1:0] byteen_q, byteen_d;
  logic [ADDR_WIDTH*NUM_LANES-1:0] addr_q, addr_d;
  logic [32*NUM_LANES-1:0] data_q, data_d, slot_q, slot_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [LW-1:0] lane;
  logic [ADDR_WIDTH-1:0] lane_addr;
  logic [31:0] old, opnd, res, merged, wdata;
  logic [3:0] be;
  logic wen, is_store;
  always_comb begin
    lane = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) if (pend_q[i]) lane = i[LW-1:0];
  end
  assign lane_addr = addr_q[32'(lane) * ADDR_WIDTH +: ADDR_WIDTH];
  assign opnd      = data_q[32'(lane) * 32 +: 32];
  assign be        = byteen_q[32'(lane) * 4 +: 4];
  assign old       = mem[lane_addr];
  assign is_store  = rw_q && amo_q == 3'd0;
  assign res = amo_q == 3'd1 ? opnd :
               amo_q == 3'd2 ? old + opnd :
               amo_q == 3'd3 ? old & opnd :
               amo_q == 3'd4 ? old | opnd :
               amo_q == 3'd5 ? old ^ opnd :
               amo_q == 3'd6 ? ($signed(old) < $signed(opnd) ? old : opnd) :
                               ($signed(old) > $signed(opnd) ? old : opnd);
  always_comb begin
    merged = old;
    for (int b = 0; b < 4; b++) if (be[b]) merged[b*8 +: 8] = opnd[b*8 +: 8];
  end
  assign wdata = amo_q != 3'd0 ? res : merged;
  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    amo_d    = amo_q;
    mask_d   = mask_q;
    pend_d   = pend_q;
    byteen_d = byteen_q;
    addr_d   = addr_q;
    data_d   = data_q;
    slot_d   = slot_q;
    tag_d    = tag_q;
    wen      = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        rw_d     = bus.req_rw;
        amo_d    = bus.req_amo;
        mask_d   = bus.req_mask;
        pend_d   = bus.req_mask;
        byteen_d = bus.req_byteen;
        addr_d   = bus.req_addr;
        data_d   = bus.req_data;
        tag_d    = bus.req_tag;
        slot_d   = '0;
        state_d  = |bus.req_mask ? SERVE : (bus.req_rw && bus.req_amo == 3'd0) ? IDLE : RESP;
      end
      SERVE: begin
        pend_d = pend_q & ~(NUM_LANES'(1) << lane);
        wen    = rw_q || amo_q != 3'd0;
        if (!is_store) slot_d[32'(lane) * 32 +: 32] = old;
        if (pend_d == '0) state_d = is_store ? IDLE : RESP;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      slot_q  <= '0;
      mask_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      slot_q  <= slot_d;
      mask_q  <= mask_d;
      tag_q   <= tag_d;
    end
    rw_q     <= rw_d;
    amo_q    <= amo_d;
    byteen_q <= byteen_d;
    addr_q   <= addr_d;
    data_q   <= data_d;
  end
  always_ff @(posedge clk) if (wen && !reset) mem[lane_addr] <= wdata;
  assign bus.req_ready = state_q == IDLE && !reset;
  assign bus.rsp_valid = state_q == RESP && !reset;
  assign bus.rsp_mask  = reset ? '0 : mask_q;
  assign bus.rsp_data  = reset ? '0 : slot_q;
  assign bus.rsp_tag   = reset ? '0 : tag_q;
endmodule

// File: tb/tb_vx_lsu_mem_responder.sv
// tb_vx_lsu_mem_responder: random and directed traffic checked every cycle against a lane-serial memory model
module tb_vx_lsu_mem_responder;
  localparam int NL = 4, AW = 10, TW = 8;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  vx_lsu_mem_responder_if #(.NUM_LANES(NL), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();
  vx_lsu_mem_responder #(.NUM_LANES(NL), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  int n_chk = 0, n_fail = 0, cyc = 0;
  int ready_at = 0, rsp_from = 0, last_acc = 0, k = 0;
  bit rsp_act = 0, post_rst = 0, er, ev, bp_rand = 0, bp_val = 1;
  logic [31:0] mmem [1024];
  logic [NL-1:0] e_mask = '0;
  logic [127:0] e_data = '0, r;
  logic [TW-1:0] e_tag = '0;
  logic [2:0] r_am;
  logic [39:0] r_ad;
  logic [127:0] r_dd;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] o, input logic [31:0] x);
    case (op)
      3'd1: return x;
      3'd2: return o + x;
      3'd3: return o & x;
      3'd4: return o | x;
      3'd5: return o ^ x;
      3'd6: return ($signed(o) < $signed(x)) ? o : x;
      default: return ($signed(o) > $signed(x)) ? o : x;
    endcase
  endfunction
  task automatic model_req(input logic rw, input logic [2:0] amo, input logic [NL-1:0] m,
                           input logic [4*NL-1:0] be, input logic [AW*NL-1:0] a,
                           input logic [32*NL-1:0] d, output logic [127:0] rr);
    int ad;
    logic [31:0] o, op;
    rr = '0;
    for (int l = 0; l < NL; l++) if (m[l]) begin
      ad = int'(a[l*AW +: AW]);
      o  = mmem[ad];
      op = d[l*32 +: 32];
      if (amo != 3'd0) begin
        rr[l*32 +: 32] = o;
        mmem[ad] = alu(amo, o, op);
      end else if (rw) begin
        for (int b = 0; b < 4; b++) if (be[l*4+b]) mmem[ad][b*8 +: 8] = op[b*8 +: 8];
      end else begin
        rr[l*32 +: 32] = o;
      end
    end
  endtask
  always @(posedge clk) #1 bus.rsp_ready = bp_rand ? ($urandom_range(0, 3) != 0) : bp_val;
  always @(negedge clk) begin
    er = !reset && cyc >= ready_at;
    ev = !reset && rsp_act && cyc >= rsp_from;
    chk("req_ready", {127'd0, bus.req_ready}, {127'd0, er});
    chk("rsp_valid", {127'd0, bus.rsp_valid}, {127'd0, ev});
    if (ev) begin
      chk("rsp_mask", {124'd0, bus.rsp_mask}, {124'd0, e_mask});
      chk("rsp_data", bus.rsp_data, e_data);
      chk("rsp_tag", {120'd0, bus.rsp_tag}, {120'd0, e_tag});
    end
    if (reset || post_rst) begin
      chk("rst_mask", {124'd0, bus.rsp_mask}, 128'd0);
      chk("rst_data", bus.rsp_data, 128'd0);
      chk("rst_tag", {120'd0, bus.rsp_tag}, 128'd0);
    end
    post_rst = reset;
    if (reset) begin
      rsp_act  = 0;
      ready_at = cyc + 1;
    end else begin
      if (ev && bus.rsp_ready) begin
        rsp_act  = 0;
        ready_at = cyc + 1;
      end
      if (er && bus.req_valid) begin
        model_req(bus.req_rw, bus.req_amo, bus.req_mask, bus.req_byteen, bus.req_addr, bus.req_data, r);
        k = $countones(bus.req_mask);
        last_acc = cyc;
        if (bus.req_rw && bus.req_amo == 3'd0) ready_at = cyc + k + 1;
        else begin
          rsp_act  = 1;
          rsp_from = cyc + k + 1;
          ready_at = 1 << 30;
          e_mask   = bus.req_mask;
          e_data   = r;
          e_tag    = bus.req_tag;
        end
      end
    end
    cyc++;
  end
  function automatic logic [39:0] pa(input int a0, input int a1, input int a2, input int a3);
    return {a3[9:0], a2[9:0], a1[9:0], a0[9:0]};
  endfunction
  task automatic issue(input logic rw, input logic [2:0] amo, input logic [3:0] m, input logic [15:0] be,
                       input logic [39:0] a, input logic [127:0] d, input logic [7:0] tg);
    int t;
    t = 0;
    bus.req_valid = 1'b1;
    bus.req_rw = rw;
    bus.req_amo = amo;
    bus.req_mask = m;
    bus.req_byteen = be;
    bus.req_addr = a;
    bus.req_data = d;
    bus.req_tag = tg;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.req_ready && t < 300);
    if (!bus.req_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got no req_ready expected ready within 300 cycles");
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(bus.req_ready && !rsp_act) && t < 300);
    if (!bus.req_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout: got busy expected idle within 300 cycles");
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mmem[i] = '0;
    bus.req_valid = 0;
    bus.req_rw = 0;
    bus.req_amo = 0;
    bus.req_mask = 0;
    bus.req_byteen = 0;
    bus.req_addr = 0;
    bus.req_data = 0;
    bus.req_tag = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) issue(1, 0, 4'hf, 16'hffff, pa(4*i, 4*i+1, 4*i+2, 4*i+3), '0, 0);
    issue(1, 0, 4'hf, 16'hffff, pa(0, 1, 2, 3), {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 8'h01);
    issue(0, 0, 4'hf, 16'h0, pa(0, 1, 2, 3), '0, 8'h5a);
    chk("pin_ld_lat", 128'(rsp_from - last_acc), 128'd5);
    chk("pin_ld_data", e_data, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    chk("pin_ld_tag", {120'd0, e_tag}, 128'h5a);
    issue(1, 0, 4'b0001, 16'h0005, pa(5, 0, 0, 0), {96'd0, 32'haabbccdd}, 8'h02);
    issue(0, 0, 4'b0001, 16'h0, pa(5, 0, 0, 0), '0, 8'h03);
    chk("pin_byteen", {96'd0, e_data[31:0]}, 128'h00bb00dd);
    issue(1, 0, 4'b0001, 16'h000f, pa(7, 0, 0, 0), {96'd0, 32'd10}, 8'h04);
    issue(0, 3'd2, 4'hf, 16'h0, pa(7, 7, 7, 7), {4{32'd1}}, 8'h05);
    chk("pin_amoadd", e_data, {32'd13, 32'd12, 32'd11, 32'd10});
    issue(0, 0, 4'b0001, 16'h0, pa(7, 0, 0, 0), '0, 8'h06);
    chk("pin_amoadd_final", {96'd0, e_data[31:0]}, 128'd14);
    issue(1, 0, 4'b0001, 16'h000f, pa(9, 0, 0, 0), {96'd0, 32'hfffffffe}, 8'h07);
    issue(0, 3'd6, 4'b1010, 16'h0, pa(0, 9, 0, 9), {32'd5, 32'd0, 32'd5, 32'd0}, 8'h08);
    chk("pin_min_lat", 128'(rsp_from - last_acc), 128'd3);
    chk("pin_min", e_data, {32'hfffffffe, 32'd0, 32'hfffffffe, 32'd0});
    issue(0, 3'd7, 4'b1010, 16'h0, pa(0, 9, 0, 9), '0, 8'h09);
    chk("pin_max", e_data, {32'd0, 32'd0, 32'hfffffffe, 32'd0});
    issue(0, 0, 4'b0001, 16'h0, pa(9, 0, 0, 0), '0, 8'h0a);
    chk("pin_max_final", {96'd0, e_data[31:0]}, 128'd0);
    wait_idle();
    bp_val = 0;
    issue(0, 0, 4'hf, 16'h0, pa(0, 1, 2, 3), '0, 8'h0b);
    repeat (15) @(posedge clk);
    bp_val = 1;
    wait_idle();
    issue(0, 0, 4'hf, 16'h0, pa(0, 1, 2, 3), '0, 8'h0c);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    issue(0, 0, 4'b0000, 16'h0, pa(0, 1, 2, 3), '0, 8'h0d);
    chk("pin_zero_lat", 128'(rsp_from - last_acc), 128'd1);
    chk("pin_zero_data", e_data, 128'd0);
    chk("pin_zero_mask", {124'd0, e_mask}, 128'd0);
    wait_idle();
    bp_rand = 1;
    for (int n = 0; n < 200; n++) begin
      r_am = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      for (int l = 0; l < 4; l++) begin
        r_ad[l*10 +: 10] = 10'($urandom_range(0, 15));
        r_dd[l*32 +: 32] = $urandom;
      end
      issue($urandom_range(0, 1) == 1, r_am, 4'($urandom), 16'($urandom), r_ad, r_dd, 8'($urandom));
    end
    wait_idle();
    bp_rand = 0;
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
